tile_pixel_encoder: RTL and testbench

- Write side of the 20x20 palette-indexed tile store used by the sprite renderer.
- Accepts a stream of 24-bit RGB pixels in raster order, for example from the loader/UART path.
- Encodes each pixel to a 4-bit palette index against the fixed 9-entry ground-tile palette and writes it into an internal 400x4 tile memory.
- Exposes a registered read port returning the index, which downstream palette logic converts back to colour.

---
 rtl/tile_pixel_encoder.sv | 155 +++++++++++++++
 tb/tb_tile_pixel_encoder.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/tile_pixel_encoder.sv
// Encodes a raster stream of RGB888 pixels into 4-bit palette indices and stores them in a 20x20 tile memory.
// Zero-latency write, 1-cycle registered read; pix_ready is high only in LOAD, with 1 pixel/clock throughput.
// Optional macro TILE_ENC_NEAREST_EN maps unmatched colours to the nearest palette entry instead of flagging err.
module tile_pixel_encoder #(
    parameter int TILE_W = 20,
    parameter int TILE_H = 20,
    parameter int DEPTH  = TILE_W * TILE_H,
    parameter int ADDR_W = 9,
    parameter int IDX_W  = 4
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              start,
    input  logic              pix_valid,
    input  logic [23:0]       pix_color,
    output logic              pix_ready,
    input  logic [ADDR_W-1:0] read_address,
    output logic [IDX_W-1:0]  output_index,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W-1:0] err_addr
);

    typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_DONE} state_t;

    localparam int                NUM_PAL = 9;
    localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);
    localparam logic [23:0] PAL [NUM_PAL] = '{
        24'h800080, 24'h888173, 24'h0A0000, 24'hFFFFEF, 24'hFFC89C,
        24'hE6570C, 24'hAB3A00, 24'h756C5F, 24'hE33F00
    };

    state_t            r_state;
    logic [ADDR_W-1:0] r_addr;
    logic [IDX_W-1:0]  r_out;
    logic [IDX_W-1:0]  r_mem [0:DEPTH-1];

    logic              w_xfer;
    logic [IDX_W-1:0]  w_idx;

    assign w_xfer       = (r_state == ST_LOAD) && pix_valid;
    assign pix_ready    = (r_state == ST_LOAD);
    assign busy         = (r_state == ST_LOAD);
    assign done         = (r_state == ST_DONE);
    assign output_index = r_out;

`ifdef TILE_ENC_NEAREST_EN
    function automatic logic [9:0] absdiff(input logic [7:0] a, input logic [7:0] b);
        return (a > b) ? {2'b00, 8'(a - b)} : {2'b00, 8'(b - a)};
    endfunction

    logic [9:0] w_dist;
    logic [9:0] w_best;

    // Strict less-than while scanning upward keeps the lowest index on ties.
    always_comb begin
        w_idx  = '0;
        w_best = '1;
        w_dist = '0;
        for (int i = 0; i < NUM_PAL; i++) begin
            w_dist = absdiff(pix_color[23:16], PAL[i][23:16])
                   + absdiff(pix_color[15:8],  PAL[i][15:8])
                   + absdiff(pix_color[7:0],   PAL[i][7:0]);
            if (w_dist < w_best) begin
                w_best = w_dist;
                w_idx  = IDX_W'(i);
            end
        end
    end

    assign err      = 1'b0;
    assign err_addr = '0;
`else
    logic              w_miss;
    logic              r_err;
    logic [ADDR_W-1:0] r_err_addr;

    // Scanning downward lets the lowest matching index overwrite any higher one.
    always_comb begin
        w_idx  = '0;
        w_miss = 1'b1;
        for (int i = NUM_PAL - 1; i >= 0; i--) begin
            if (pix_color == PAL[i]) begin
                w_idx  = IDX_W'(i);
                w_miss = 1'b0;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_err      <= 1'b0;
            r_err_addr <= '0;
        end else if ((r_state != ST_LOAD) && start) begin
            r_err      <= 1'b0;
            r_err_addr <= '0;
        end else if (w_xfer && w_miss && !r_err) begin
            r_err      <= 1'b1;
            r_err_addr <= r_addr;
        end
    end

    assign err      = r_err;
    assign err_addr = r_err_addr;
`endif

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state <= ST_IDLE;
            r_addr  <= '0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        r_state <= ST_LOAD;
                        r_addr  <= '0;
                    end
                end
                ST_LOAD: begin
                    if (w_xfer) begin
                        if (r_addr == LAST) begin
                            r_state <= ST_DONE;
                            r_addr  <= '0;
                        end else begin
                            r_addr <= r_addr + ADDR_W'(1);
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_addr  <= '0;
                end
            endcase
        end
    end

    // Memory is never cleared; reset only blocks a write issued in the same cycle.
    always_ff @(posedge Clk) begin
        if (!Reset && w_xfer) begin
            r_mem[r_addr] <= w_idx;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_out <= '0;
        end else if (read_address <= LAST) begin
            r_out <= r_mem[read_address];
        end else begin
            r_out <= '0;
        end
    end

endmodule

// File: tb/tb_tile_pixel_encoder.sv
// Scoreboard bench for tile_pixel_encoder: full loads, mismatch pixels, gapped valid, ignored start, mid-load reset, read-during-write.
module tb_tile_pixel_encoder;

    logic        Clk = 1'b0;
    logic        Reset = 1'b0;
    logic        start = 1'b0;
    logic        pix_valid = 1'b0;
    logic [23:0] pix_color = '0;
    logic        pix_ready;
    logic [8:0]  read_address = '0;
    logic [3:0]  output_index;
    logic        busy;
    logic        done;
    logic        err;
    logic [8:0]  err_addr;

    tile_pixel_encoder dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .start        (start),
        .pix_valid    (pix_valid),
        .pix_color    (pix_color),
        .pix_ready    (pix_ready),
        .read_address (read_address),
        .output_index (output_index),
        .busy         (busy),
        .done         (done),
        .err          (err),
        .err_addr     (err_addr)
    );

    always #5 Clk = ~Clk;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [23:0] pal [9];
    int          ref_mem [400];
    int          sb [$];

    task automatic check_val(input string tag, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    function automatic int model_idx(input logic [23:0] c);
        int idx;
        idx = 0;
`ifdef TILE_ENC_NEAREST_EN
        begin
            int best, d, dr, dg, db;
            best = 100000;
            for (int i = 0; i < 9; i++) begin
                dr = int'(c[23:16]) - int'(pal[i][23:16]);
                dg = int'(c[15:8])  - int'(pal[i][15:8]);
                db = int'(c[7:0])   - int'(pal[i][7:0]);
                d  = (dr < 0 ? -dr : dr) + (dg < 0 ? -dg : dg) + (db < 0 ? -db : db);
                if (d < best) begin
                    best = d;
                    idx  = i;
                end
            end
        end
`else
        for (int i = 8; i >= 0; i--)
            if (c == pal[i]) idx = i;
`endif
        return idx;
    endfunction

    function automatic bit model_miss(input logic [23:0] c);
        for (int i = 0; i < 9; i++)
            if (c == pal[i]) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [23:0] pixel(input int pat, input int n);
        case (pat)
            0:       return pal[n % 9];
            1:       return (n == 37 || n == 200) ? 24'h123456 : 24'hFFFFEF;
            2:       return pal[(n * 7 + 3) % 9];
            default: return pal[(n + 4) % 9];
        endcase
    endfunction

    task automatic pop_check(input string tag);
        int exp;
        if (sb.size() == 0) begin
            check_val({tag, "_sb_empty"}, 0, 1);
        end else begin
            exp = sb.pop_front();
            if (exp >= 0) check_val(tag, int'(output_index), exp);
        end
    endtask

    // Reads back at the current write address each cycle, so every write also checks old-data read.
    task automatic load(input int pat, input bit gaps, input int start_at, input int rst_at);
        int n, cyc, exp_err, exp_err_addr;
        bit v, rst;
        n = 0; cyc = 0; exp_err = 0; exp_err_addr = 0;
        start = 1'b1;
        step();
        start = 1'b0;
        check_val("busy_after_start", int'(busy), 1);
        check_val("err_cleared", int'(err), 0);
        while (n < 400 && cyc < 4000) begin
            v            = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            pix_valid    = v;
            pix_color    = pixel(pat, n);
            read_address = 9'(n);
            rst          = (n == rst_at) && v;
            Reset        = rst;
            start        = (n == start_at) && v;
            check_val("done_early", int'(done), 0);
            check_val("ready_in_load", int'(pix_ready), 1);
            sb.push_back(rst ? 0 : ref_mem[n]);
            step();
            pop_check("rd_during_wr");
            Reset = 1'b0;
            start = 1'b0;
            if (rst) begin
                pix_valid = 1'b0;
                check_val("rst_busy", int'(busy), 0);
                check_val("rst_done", int'(done), 0);
                check_val("rst_ready", int'(pix_ready), 0);
                return;
            end
            if (v) begin
                ref_mem[n] = model_idx(pix_color);
`ifndef TILE_ENC_NEAREST_EN
                if (model_miss(pix_color) && exp_err == 0) begin
                    exp_err      = 1;
                    exp_err_addr = n;
                end
`endif
                n++;
            end
            cyc++;
        end
        check_val("xfer_count", n, 400);
        check_val("done_set", int'(done), 1);
        check_val("busy_clr", int'(busy), 0);
        check_val("ready_clr", int'(pix_ready), 0);
        check_val("err", int'(err), exp_err);
        check_val("err_addr", int'(err_addr), exp_err_addr);
        pix_valid = 1'b1;
        pix_color = pal[5];
        repeat (3) step();
        pix_valid = 1'b0;
        check_val("done_holds", int'(done), 1);
    endtask

    task automatic sweep();
        for (int a = 0; a <= 400; a++) begin
            read_address = (a == 400) ? 9'd450 : 9'(a);
            sb.push_back((a == 400) ? 0 : ref_mem[a]);
            step();
            pop_check((a == 400) ? "rd_oob" : "rd_sweep");
        end
    endtask

    initial begin
        pal = '{24'h800080, 24'h888173, 24'h0A0000, 24'hFFFFEF, 24'hFFC89C,
                24'hE6570C, 24'hAB3A00, 24'h756C5F, 24'hE33F00};
        foreach (ref_mem[i]) ref_mem[i] = -1;

        Reset = 1'b1;
        repeat (2) step();
        check_val("rst_ready", int'(pix_ready), 0);
        check_val("rst_busy", int'(busy), 0);
        check_val("rst_done", int'(done), 0);
        check_val("rst_err", int'(err), 0);
        check_val("rst_err_addr", int'(err_addr), 0);
        check_val("rst_out", int'(output_index), 0);
        Reset = 1'b0;
        step();
        check_val("idle_busy", int'(busy), 0);

        load(0, 1'b0, -1, -1);
        sweep();

        load(1, 1'b0, -1, -1);
        sweep();
`ifdef TILE_ENC_NEAREST_EN
        check_val("nearest_123456", ref_mem[37], 2);
`else
        check_val("miss_idx_37", ref_mem[37], 0);
`endif

        load(2, 1'b1, 100, -1);
        sweep();

        load(0, 1'b0, -1, -1);
        load(3, 1'b0, -1, 250);
        check_val("idle_after_rst_done", int'(done), 0);
        sweep();
        load(3, 1'b0, -1, -1);
        sweep();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
